// File: rtl/dct_perm_serializer.sv
// Output reorder and serialiser for the DCT-II partial butterfly: captures one vector of
// butterfly outputs and streams it LANES coefficients per beat in natural order.
// Optional high-frequency zero-out is enabled with the DCT_PERM_ZO_EN macro.
module dct_perm_serializer #(
  parameter int DW        = 16,
  parameter int LOG2_MAXN = 5,
  parameter int LANES     = 4,
  parameter int ZO_KEEP   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_log2n,
  input  logic [(1<<LOG2_MAXN)*DW-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DW-1:0]        out_data,
  output logic [LANES-1:0]           out_mask,
  output logic                       out_last,
  output logic [LOG2_MAXN-1:0]       out_beat,
  output logic                       err_size
);

  localparam int MAXN = 1 << LOG2_MAXN;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_r;
  logic [MAXN*DW-1:0]     data_r;
  logic [2:0]             n_r;
  logic                   out_valid_r;
  logic                   out_last_r;
  logic [LOG2_MAXN-1:0]   out_beat_r;
  logic [LANES*DW-1:0]    out_data_r;
  logic [LANES-1:0]       out_mask_r;
  logic                   err_r;

  logic                   legal_s;
  logic [2:0]             n_eff_s;
  logic                   handshake_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic [LOG2_MAXN-1:0]   next_beat_s;

  // Index of the last beat for a transform of size 2^n.
  function automatic logic [LOG2_MAXN-1:0] last_beat(input logic [2:0] n);
    int keep;
    int b;
    keep = 1 << n;
`ifdef DCT_PERM_ZO_EN
    if (keep > ZO_KEEP) keep = ZO_KEEP;
`endif
    b = keep / LANES;
    if (b < 1) b = 1;
    return LOG2_MAXN'(b - 1);
  endfunction

  // Coefficient c is emitted as data only if it lies inside the transform (and the kept band).
  function automatic logic lane_live(input int c, input int n);
`ifdef DCT_PERM_ZO_EN
    return (c < (1 << n)) && (c < ZO_KEEP);
`else
    return c < (1 << n);
`endif
  endfunction

  // Input word holding coefficient c: stage m = n - tz(c) odd part, position ((c>>t)-1)/2.
  function automatic int word_index(input int c, input int n);
    int t;
    int m;
    if (c == 0) return 0;
    t = 0;
    for (int b = LOG2_MAXN - 1; b >= 0; b--) begin
      if (c[b]) t = b;
    end
    m = n - t;
    return (1 << (m - 1)) + (((c >> t) - 1) >> 1);
  endfunction

  function automatic logic [LANES*DW-1:0] map_data(input logic [MAXN*DW-1:0] src,
                                                    input logic [2:0] n,
                                                    input logic [LOG2_MAXN-1:0] beat);
    logic [LANES*DW-1:0] d;
    int c;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      c = int'(beat) * LANES + k;
      if (lane_live(c, int'(n))) d[k*DW +: DW] = src[word_index(c, int'(n))*DW +: DW];
    end
    return d;
  endfunction

  function automatic logic [LANES-1:0] map_mask(input logic [2:0] n,
                                                input logic [LOG2_MAXN-1:0] beat);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      m[k] = lane_live(int'(beat) * LANES + k, int'(n));
    end
    return m;
  endfunction

  // Handshake decode and size legalisation.
  always_comb begin
    legal_s     = (in_log2n >= 3'd2) && (in_log2n <= 3'(LOG2_MAXN));
    n_eff_s     = legal_s ? in_log2n : 3'(LOG2_MAXN);
    handshake_s = out_valid_r && out_ready;
    in_ready_s  = (state_r == IDLE) || (handshake_s && out_last_r);
    accept_s    = in_valid && in_ready_s;
    next_beat_s = out_beat_r + LOG2_MAXN'(1);
  end

  // Capture/send state machine with registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= '0;
      n_r         <= 3'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_beat_r  <= '0;
      out_data_r  <= '0;
      out_mask_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r <= accept_s && !legal_s;
      if (accept_s) begin
        // Beat 0 is mapped straight from in_data so it is valid the cycle after acceptance.
        state_r     <= SEND;
        data_r      <= in_data;
        n_r         <= n_eff_s;
        out_valid_r <= 1'b1;
        out_beat_r  <= '0;
        out_data_r  <= map_data(in_data, n_eff_s, '0);
        out_mask_r  <= map_mask(n_eff_s, '0);
        out_last_r  <= (last_beat(n_eff_s) == '0);
      end else if (handshake_s) begin
        if (out_last_r) begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end else begin
          out_beat_r  <= next_beat_s;
          out_data_r  <= map_data(data_r, n_r, next_beat_s);
          out_mask_r  <= map_mask(n_r, next_beat_s);
          out_last_r  <= (next_beat_s == last_beat(n_r));
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_mask  = out_mask_r;
  assign out_last  = out_last_r;
  assign out_beat  = out_beat_r;
  assign err_size  = err_r;

endmodule
